// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the instruction-fetch (I) and data (D) requesters.
// D has fixed priority; a starvation counter forces an I grant after STARVE_MAX D wins.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam int unsigned LAT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic               owner_d_q, owner_d_d;
  logic               write_q, write_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic               i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [31:0]        i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic               mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic [31:0]        mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic               busy_q, busy_d;
  logic               d_wins_c;

  // D wins unless it has starved a pending I for STARVE_MAX grants
  assign d_wins_c = d_req && ((cnt_q < CNT_W'(STARVE_MAX)) || !i_req);

  always_comb begin
    state_d     = state_q;
    owner_d_d   = owner_d_q;
    write_d     = write_q;
    lat_d       = lat_q;
    cnt_d       = cnt_q;
    i_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    i_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d  = ACCESS;
          mem_en_d = 1'b1;
          if (d_wins_c) begin
            owner_d_d   = 1'b1;
            write_d     = d_we;
            d_gnt_d     = 1'b1;
            mem_we_d    = d_we;
            mem_be_d    = d_be;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (!i_req)
              cnt_d = '0;
            else if (cnt_q != CNT_W'(STARVE_MAX))
              cnt_d = cnt_q + CNT_W'(1);
          end else begin
            owner_d_d  = 1'b0;
            write_d    = 1'b0;
            i_gnt_d    = 1'b1;
            mem_be_d   = 4'hF;
            mem_addr_d = i_addr;
            cnt_d      = '0;
          end
        end
      end
      ACCESS: begin
        if (write_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          lat_d   = LAT_W'(MEM_LAT - 1);
        end
      end
      WAIT: begin
        // Last WAIT cycle is the one where mem_rdata is valid
        if (lat_q == '0) begin
          state_d = RESP;
          if (owner_d_q) begin
            d_rdata_d  = mem_rdata;
            d_rvalid_d = 1'b1;
          end else begin
            i_rdata_d  = mem_rdata;
            i_rvalid_d = 1'b1;
          end
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      write_q     <= 1'b0;
      lat_q       <= '0;
      cnt_q       <= '0;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_d_q   <= owner_d_d;
      write_q     <= write_d;
      lat_q       <= lat_d;
      cnt_q       <= cnt_d;
      i_gnt_q     <= i_gnt_d;
      d_gnt_q     <= d_gnt_d;
      i_rvalid_q  <= i_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_rvalid  = i_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance A (MEM_LAT=1) and instance B (MEM_LAT=3).
module tb_mem_port_arbiter;

  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;
  localparam int unsigned SMAX  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we, a_busy;
  logic [3:0]  a_mem_be;
  logic [31:0] a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_d_req, b_d_we;
  logic [3:0]  b_d_be;
  logic [31:0] b_d_addr, b_d_wdata;
  logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy;
  logic [3:0]  b_mem_be;
  logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.MEM_LAT(LAT_A), .STARVE_MAX(SMAX)) u_dut_a (
    .clk(clk), .reset(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.MEM_LAT(LAT_B), .STARVE_MAX(SMAX)) u_dut_b (
    .clk(clk), .reset(rst_n),
    .i_req(1'b0), .i_addr(32'h0), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h3000) return 32'h2402000A;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Memory models: read data valid only in the MEM_LAT-th cycle after mem_en
  logic        a_v = 1'b0;
  logic [31:0] a_p;
  always @(posedge clk) begin
    a_v <= a_mem_en & ~a_mem_we;
    a_p <= mem_f(a_mem_addr);
  end
  assign a_mem_rdata = a_v ? a_p : 32'hBAD0BAD0;

  logic [2:0]  b_v = 3'b000;
  logic [31:0] b_p0, b_p1, b_p2;
  always @(posedge clk) begin
    b_v  <= {b_v[1:0], b_mem_en & ~b_mem_we};
    b_p0 <= mem_f(b_mem_addr);
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_mem_rdata = b_v[2] ? b_p2 : 32'hBAD0BAD0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct { logic [31:0] data; int gcyc; } rsp_t;
  req_t iq[$], dq[$];
  rsp_t irq[$], drq[$];
  bit   glog[$];
  req_t mr;
  rsp_t ms;

  // Scoreboard monitor for instance A
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (a_i_gnt || a_d_gnt) begin
        chk("one_gnt", 32'(a_i_gnt & a_d_gnt), 32'd0);
        chk("gnt_vs_rvalid", 32'(a_i_rvalid | a_d_rvalid), 32'd0);
        chk("gnt_mem_en", 32'(a_mem_en), 32'd1);
        glog.push_back(a_d_gnt);
      end
      if (a_i_gnt) begin
        if (iq.size() == 0) chk("i_gnt_unexp", 32'(a_i_gnt), 32'd0);
        else begin
          mr = iq.pop_front();
          chk("i_mem_we", 32'(a_mem_we), 32'd0);
          chk("i_mem_be", 32'(a_mem_be), 32'hF);
          chk("i_mem_addr", a_mem_addr, mr.addr);
          irq.push_back('{data: mem_f(mr.addr), gcyc: cyc});
        end
      end
      if (a_d_gnt) begin
        if (dq.size() == 0) chk("d_gnt_unexp", 32'(a_d_gnt), 32'd0);
        else begin
          mr = dq.pop_front();
          chk("d_mem_we", 32'(a_mem_we), 32'(mr.we));
          chk("d_mem_be", 32'(a_mem_be), 32'(mr.be));
          chk("d_mem_addr", a_mem_addr, mr.addr);
          if (mr.we) chk("d_mem_wdata", a_mem_wdata, mr.wdata);
          else drq.push_back('{data: mem_f(mr.addr), gcyc: cyc});
        end
      end
      if (a_i_rvalid) begin
        if (irq.size() == 0) chk("i_rvalid_unexp", 32'(a_i_rvalid), 32'd0);
        else begin
          ms = irq.pop_front();
          chk("i_rdata", a_i_rdata, ms.data);
          chk("i_rsp_lat", 32'(cyc - ms.gcyc), 32'(LAT_A + 1));
        end
      end
      if (a_d_rvalid) begin
        if (drq.size() == 0) chk("d_rvalid_unexp", 32'(a_d_rvalid), 32'd0);
        else begin
          ms = drq.pop_front();
          chk("d_rdata", a_d_rdata, ms.data);
          chk("d_rsp_lat", 32'(cyc - ms.gcyc), 32'(LAT_A + 1));
        end
      end
    end
  end

  task automatic do_i(input logic [31:0] addr, output int n);
    req_t r;
    r.we = 1'b0; r.be = 4'hF; r.addr = addr; r.wdata = '0;
    iq.push_back(r);
    i_req = 1'b1; i_addr = addr; n = 0;
    do begin @(negedge clk); n++; end while (!a_i_gnt && n < 200);
    chk("i_gnt_timeout", 32'(a_i_gnt), 32'd1);
    i_req = 1'b0;
  endtask

  task automatic do_d(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, output int n);
    req_t r;
    r.we = we; r.be = be; r.addr = addr; r.wdata = wdata;
    dq.push_back(r);
    d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata; n = 0;
    do begin @(negedge clk); n++; end while (!a_d_gnt && n < 200);
    chk("d_gnt_timeout", 32'(a_d_gnt), 32'd1);
    d_req = 1'b0;
  endtask

  int n1, n2;

  initial begin
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    b_d_req = 1'b0; b_d_we = 1'b0; b_d_be = '0; b_d_addr = '0; b_d_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_ctl", 32'({a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we, a_busy, a_mem_be}), 32'd0);
    chk("rst_a_data", a_i_rdata | a_d_rdata | a_mem_addr | a_mem_wdata, 32'd0);
    chk("rst_b_ctl", 32'({b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy, b_mem_be}), 32'd0);
    chk("rst_b_data", b_i_rdata | b_d_rdata | b_mem_addr | b_mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Lone I read
    do_i(32'h3000, n1);
    chk("t1_gnt_lat", 32'(n1), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t1_rvalid", 32'(a_i_rvalid), 32'd1);
    chk("t1_rdata", a_i_rdata, 32'h2402000A);
    repeat (2) @(negedge clk);

    // D writes, including a zero byte-enable write, then back-to-back reads
    do_d(1'b1, 4'b0011, 32'h10, 32'hDEADBEEF, n1);
    chk("t2_gnt_lat", 32'(n1), 32'd1);
    do_d(1'b1, 4'b0000, 32'h14, 32'h12345678, n1);
    chk("t2_wr_wr_gap", 32'(n1), 32'd2);
    @(negedge clk);
    chk("t2_busy_after_wr", 32'(a_busy), 32'd0);
    chk("t2_no_rvalid", 32'(a_d_rvalid), 32'd0);
    do_d(1'b0, 4'hF, 32'h20, 32'h0, n1);
    do_d(1'b0, 4'hF, 32'h24, 32'h0, n1);
    chk("t2_rd_rd_gap", 32'(n1), 32'(LAT_A + 3));
    repeat (5) @(negedge clk);

    // Simultaneous requests: D first, I after D's response
    fork
      do_i(32'h3004, n1);
      do_d(1'b0, 4'hF, 32'h20, 32'h0, n2);
    join
    chk("t3_d_first", 32'(n2), 32'd1);
    chk("t3_i_after", 32'(n1), 32'(LAT_A + 4));
    repeat (5) @(negedge clk);

    // Both held continuously: starvation counter forces every fifth grant to I
    glog.delete();
    fork
      begin
        for (int k = 0; k < 2; k++) do_i(32'h100 + 32'(4 * k), n1);
      end
      begin
        for (int k = 0; k < 8; k++)
          do_d(k[0], 4'(k + 1), 32'h200 + 32'(4 * k), 32'hC0DE0000 + 32'(k), n2);
      end
    join
    repeat (5) @(negedge clk);
    chk("t4_grant_count", 32'(glog.size()), 32'd10);
    for (int k = 0; k < 10 && k < glog.size(); k++)
      chk($sformatf("t4_order_%0d", k), 32'(glog[k]), 32'((k % 5) != 4));

    // MEM_LAT=3 D read on instance B
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_be = 4'hF; b_d_addr = 32'h40; b_d_wdata = '0;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      chk($sformatf("t5_gnt_T%0d", t), 32'(b_d_gnt), 32'(t == 1));
      chk($sformatf("t5_mem_en_T%0d", t), 32'(b_mem_en), 32'(t == 1));
      chk($sformatf("t5_busy_T%0d", t), 32'(b_busy), 32'(t <= 5));
      chk($sformatf("t5_rvalid_T%0d", t), 32'(b_d_rvalid), 32'(t == 5));
      chk($sformatf("t5_i_idle_T%0d", t), 32'(b_i_gnt | b_i_rvalid), 32'd0);
      if (t == 1) begin
        chk("t5_mem_addr", b_mem_addr, 32'h40);
        b_d_req = 1'b0;
      end
      if (t == 4) chk("t5_rdata_hold", b_d_rdata, 32'd0);
      if (t == 5) chk("t5_rdata", b_d_rdata, mem_f(32'h40));
    end

    // Reset during the read's WAIT cycle aborts it
    do_d(1'b0, 4'hF, 32'h44, 32'h0, n1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_ctl", 32'({a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we, a_busy, a_mem_be}), 32'd0);
    chk("t6_rst_data", a_i_rdata | a_d_rdata | a_mem_addr | a_mem_wdata, 32'd0);
    drq.delete();
    rst_n = 1'b1;
    do_i(32'h3000, n1);
    chk("t6_regrant_lat", 32'(n1), 32'd1);
    repeat (6) @(negedge clk);

    chk("end_iq", 32'(iq.size() + dq.size()), 32'd0);
    chk("end_rsp", 32'(irq.size() + drq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
